// File: rtl/multicyc_pkg.sv
// -----------------------------------------------------------------------------
// multicyc_pkg
// Shared types for the EX-stage multi-cycle (HI/LO) unit: operation encoding,
// controller state enum, request/response bundles and op-class helpers.
// -----------------------------------------------------------------------------
package multicyc_pkg;

  // Divider iteration count equals the operand width.
  localparam int DIV_ITER = 32;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MADD  = 4'd5,
    OP_MADDU = 4'd6,
    OP_MSUB  = 4'd7,
    OP_MSUBU = 4'd8,
    OP_MTHI  = 4'd9,
    OP_MTLO  = 4'd10
  } oper_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } multicyc_state_t;

  typedef struct packed {
    oper_t       op;
    logic [31:0] reg0;
    logic [31:0] reg1;
    logic [63:0] hilo;
  } multicyc_req_t;

  typedef struct packed {
    logic        ready;
    logic        hilo_we;
    logic [63:0] hilo;
  } multicyc_resp_t;

  // Ops routed through the multiplier (plain and accumulate variants).
  function automatic logic is_mul_op(input oper_t op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
           (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_div_op(input oper_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input oper_t op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/multicyc_ctrl_div.sv
// -----------------------------------------------------------------------------
// div_iter
// Restoring divider datapath, one quotient bit per step. Operands are reduced
// to magnitudes at start (signed mode) and the signs are reapplied on fix.
// Ports:
//   clk         clock
//   start_i     load operands, clear remainder accumulator
//   step_i      perform one shift/subtract iteration
//   fix_i       apply sign correction to quotient and remainder
//   signed_i    operands are two's-complement (sampled with start_i)
//   dividend_i  rs operand
//   divisor_i   rt operand
//   result_o    {remainder, quotient}
// -----------------------------------------------------------------------------
module div_iter
  import multicyc_pkg::*;
(
  input  logic                  clk,
  input  logic                  start_i,
  input  logic                  step_i,
  input  logic                  fix_i,
  input  logic                  signed_i,
  input  logic [DIV_ITER-1:0]   dividend_i,
  input  logic [DIV_ITER-1:0]   divisor_i,
  output logic [2*DIV_ITER-1:0] result_o
);

  localparam int W = DIV_ITER;

  logic [W-1:0] rem_q, quo_q, dvs_q;
  logic         neg_quo_q, neg_rem_q;

  logic         dvd_neg, dvs_neg;
  logic [W-1:0] dvd_abs, dvs_abs;
  logic [W:0]   rem_sh, diff;
  logic         q_bit;
  logic [W-1:0] rem_nxt;

  always_comb begin
    dvd_neg = signed_i & dividend_i[W-1];
    dvs_neg = signed_i & divisor_i[W-1];
    dvd_abs = dvd_neg ? -dividend_i : dividend_i;
    dvs_abs = dvs_neg ? -divisor_i  : divisor_i;
    // Shift the next dividend bit into the partial remainder. The remainder
    // stays below the divisor, so the shifted value fits W+1 bits and the
    // borrow (diff MSB) alone decides whether the subtraction is kept.
    rem_sh  = {rem_q, quo_q[W-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    q_bit   = ~diff[W];
    rem_nxt = q_bit ? diff[W-1:0] : rem_sh[W-1:0];
  end

  // The dividend magnitude lives in quo_q and is shifted out as quotient
  // bits are shifted in. A zero divisor naturally yields an all-ones
  // quotient and leaves the dividend as the remainder.
  always_ff @(posedge clk) begin
    if (start_i) begin
      quo_q     <= dvd_abs;
      rem_q     <= '0;
      dvs_q     <= dvs_abs;
      neg_quo_q <= dvd_neg ^ dvs_neg;
      neg_rem_q <= dvd_neg;
    end else if (step_i) begin
      rem_q <= rem_nxt;
      quo_q <= {quo_q[W-2:0], q_bit};
    end else if (fix_i) begin
      if (neg_quo_q) quo_q <= -quo_q;
      if (neg_rem_q) rem_q <= -rem_q;
    end
  end

  assign result_o = {rem_q, quo_q};

endmodule

// File: rtl/multicyc_ctrl.sv
// -----------------------------------------------------------------------------
// multicyc_ctrl
// Sequencing controller for the EX-stage multi-cycle unit. Accepts one HI/LO
// op at a time, runs it to completion and hands the result back to EX.
// Ports:
//   clk        clock
//   rst        synchronous active-low reset
//   req_valid  EX presents an op (held stable until ack)
//   req_op     operation
//   req_reg0   rs operand
//   req_reg1   rt operand
//   hilo_rd    current {HI,LO}
//   ack        EX accepts the result
//   flush      abort any in-flight op, suppress the write
//   busy       controller is not idle
//   ready      result valid for EX
//   hilo_we    one-cycle HI/LO write strobe
//   hilo_wr    {HI,LO} result
// -----------------------------------------------------------------------------
module multicyc_ctrl
  import multicyc_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  oper_t       req_op,
  input  logic [31:0] req_reg0,
  input  logic [31:0] req_reg1,
  input  logic [63:0] hilo_rd,
  input  logic        ack,
  input  logic        flush,
  output logic        busy,
  output logic        ready,
  output logic        hilo_we,
  output logic [63:0] hilo_wr
);

  // Wide enough for DIV_ITER-1 and any MUL_LAT-1 up to 255.
  localparam int                CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_ITER - 1);

  multicyc_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  oper_t            op_q;
  logic [63:0]      hilo_q, prod_q, mul_res_q;

  multicyc_req_t    req;
  multicyc_resp_t   resp;

  logic             mul_start, mul_done;
  logic             div_start, div_step, div_fix;
  logic signed [63:0] mul_a, mul_b;
  logic [63:0]      prod, mul_res, div_res;

  assign req = '{op: req_op, reg0: req_reg0, reg1: req_reg1, hilo: hilo_rd};

  // Sign/zero extension straight to 64 bits gives the same low 64 product
  // bits as a 33x33 multiply, which is all HI/LO keeps.
  always_comb begin
    mul_a = is_signed_op(req.op) ? {{32{req.reg0[31]}}, req.reg0} : {32'b0, req.reg0};
    mul_b = is_signed_op(req.op) ? {{32{req.reg1[31]}}, req.reg1} : {32'b0, req.reg1};
    prod  = mul_a * mul_b;
  end

  // Accumulate variants use the HI/LO value captured at accept; nothing can
  // write HI/LO while the unit is busy, so no forwarding is needed.
  always_comb begin
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = hilo_q + prod_q;
      OP_MSUB, OP_MSUBU: mul_res = hilo_q - prod_q;
      default:           mul_res = prod_q;
    endcase
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_start = 1'b0;
    mul_done  = 1'b0;
    div_start = 1'b0;
    div_step  = 1'b0;
    div_fix   = 1'b0;
    resp      = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req.op == OP_MTHI) begin
            resp.ready   = 1'b1;
            resp.hilo_we = ack;
            resp.hilo    = {req.reg0, req.hilo[31:0]};
          end else if (req.op == OP_MTLO) begin
            resp.ready   = 1'b1;
            resp.hilo_we = ack;
            resp.hilo    = {req.hilo[63:32], req.reg0};
          end else if (is_mul_op(req.op)) begin
            mul_start = 1'b1;
            cnt_d     = MUL_INIT;
            state_d   = ST_MUL;
          end else if (is_div_op(req.op)) begin
            div_start = 1'b1;
            cnt_d     = DIV_INIT;
            state_d   = ST_DIV;
          end
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          mul_done = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DIV: begin
        div_step = 1'b1;
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      ST_FIX: begin
        div_fix = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        resp.ready   = 1'b1;
        resp.hilo_we = ack;
        resp.hilo    = is_div_op(op_q) ? div_res : mul_res_q;
        if (ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush overrides everything but reset: abandon the op, never write.
    if (flush) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      mul_start    = 1'b0;
      div_start    = 1'b0;
      resp.hilo_we = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: datapath registers carry no reset; they are only observed in DONE,
  // which is reachable solely after they have been loaded.
  always_ff @(posedge clk) begin
    if (mul_start || div_start) op_q <= req.op;
    if (mul_start) begin
      hilo_q <= req.hilo;
      prod_q <= prod;
    end
    if (mul_done) mul_res_q <= mul_res;
  end

  div_iter u_div (
    .clk        (clk),
    .start_i    (div_start),
    .step_i     (div_step),
    .fix_i      (div_fix),
    .signed_i   (is_signed_op(req.op)),
    .dividend_i (req.reg0),
    .divisor_i  (req.reg1),
    .result_o   (div_res)
  );

  assign busy    = (state_q != ST_IDLE);
  assign ready   = resp.ready;
  assign hilo_we = resp.hilo_we;
  assign hilo_wr = resp.hilo;

endmodule

// File: tb/tb_multicyc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicyc_ctrl
// Self-checking bench for multicyc_ctrl: directed vector table, multi-cycle
// corner sequences (ack stall, flush, reset) and randomized ops checked
// against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_multicyc_ctrl;
  import multicyc_pkg::*;

  localparam int MUL_LAT = 2;
  localparam int MAX_WAIT = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  oper_t       req_op = OP_NONE;
  logic [31:0] req_reg0 = '0;
  logic [31:0] req_reg1 = '0;
  logic [63:0] hilo_rd = '0;
  logic        ack = 1'b0;
  logic        flush = 1'b0;
  logic        busy, ready, hilo_we;
  logic [63:0] hilo_wr;

  int n_tests = 0;
  int n_fail  = 0;

  multicyc_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_reg0  (req_reg0),
    .req_reg1  (req_reg1),
    .hilo_rd   (hilo_rd),
    .ack       (ack),
    .flush     (flush),
    .busy      (busy),
    .ready     (ready),
    .hilo_we   (hilo_we),
    .hilo_wr   (hilo_wr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: result from plain arithmetic on the architectural rules.
  function automatic logic [63:0] model_result(input oper_t op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] hilo);
    longint      sa, sb;
    logic [63:0] sp, up;
    int          ia, ib;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sp = 64'(sa * sb);
    up = {32'b0, a} * {32'b0, b};
    case (op)
      OP_MULT:  return sp;
      OP_MULTU: return up;
      OP_MADD:  return hilo + sp;
      OP_MADDU: return hilo + up;
      OP_MSUB:  return hilo - sp;
      OP_MSUBU: return hilo - up;
      OP_DIVU:  begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      OP_DIV: begin
        if (b == 0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        ia = $signed(a);
        ib = $signed(b);
        q  = 32'(ia / ib);
        r  = 32'(ia % ib);
        return {r, q};
      end
      OP_MTHI:  return {a, hilo[31:0]};
      OP_MTLO:  return {hilo[63:32], a};
      default:  return 64'd0;
    endcase
  endfunction

  function automatic int model_latency(input oper_t op);
    if (op == OP_MTHI || op == OP_MTLO) return 0;
    if (op == OP_DIV || op == OP_DIVU)  return DIV_ITER + 2;
    return MUL_LAT + 1;
  endfunction

  // Present one op, measure cycles to ready, stall ack for ack_delay cycles,
  // then ack and confirm the unit returns to idle.
  task automatic run_op(input string name, input oper_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] hilo, input int ack_delay,
                        input logic [63:0] exp, input int exp_lat);
    int   lat;
    int   held_bad;
    logic stray;
    req_valid = 1'b1;
    req_op    = op;
    req_reg0  = a;
    req_reg1  = b;
    hilo_rd   = hilo;
    ack       = 1'b0;
    #1;
    lat   = 0;
    stray = 1'b0;
    while (!ready && lat < MAX_WAIT) begin
      stray |= hilo_we;
      step();
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    held_bad = 0;
    for (int k = 0; k < ack_delay; k++) begin
      if (!ready || hilo_we || hilo_wr !== exp) held_bad++;
      step();
    end
    check({name, "_stall_hold"}, 64'(held_bad), 64'd0);
    check({name, "_early_we"}, 64'(stray), 64'd0);
    ack = 1'b1;
    #1;
    check({name, "_hilo_wr"}, hilo_wr, exp);
    check({name, "_hilo_we"}, 64'(hilo_we), 64'd1);
    step();
    req_valid = 1'b0;
    ack       = 1'b0;
    #1;
    check({name, "_idle_after"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    string       name;
    oper_t       op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] hilo;
    int          ack_delay;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t  vecs[$];
    oper_t ops[10];
    int    wait_n;

    vecs.push_back('{"mult_neg2x3",  OP_MULT,  32'hFFFF_FFFE, 32'd3,        64'd0,                 0, 64'hFFFF_FFFF_FFFF_FFFA, 3});
    vecs.push_back('{"div_m7_2",     OP_DIV,   32'hFFFF_FFF9, 32'd2,        64'd0,                 0, 64'hFFFF_FFFF_FFFF_FFFD, 34});
    vecs.push_back('{"divu_by0",     OP_DIVU,  32'd100,       32'd0,        64'd0,                 0, 64'h0000_0064_FFFF_FFFF, 34});
    vecs.push_back('{"msubu_wrap",   OP_MSUBU, 32'd1,         32'd1,        64'd0,                 0, 64'hFFFF_FFFF_FFFF_FFFF, 3});
    vecs.push_back('{"multu_stall5", OP_MULTU, 32'd7,         32'd6,        64'd0,                 5, 64'd42,                  3});
    vecs.push_back('{"div_ovf",      OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'd0,                0, 64'h0000_0000_8000_0000, 34});
    vecs.push_back('{"div_neg_by0",  OP_DIV,   32'hFFFF_FFF8, 32'd0,        64'd0,                 0, 64'hFFFF_FFF8_0000_0001, 34});
    vecs.push_back('{"div_pos_by0",  OP_DIV,   32'd7,         32'd0,        64'd0,                 0, 64'h0000_0007_FFFF_FFFF, 34});
    vecs.push_back('{"madd_neg",     OP_MADD,  32'd2,         32'hFFFF_FFFD, 64'd1,                0, 64'hFFFF_FFFF_FFFF_FFFB, 3});
    vecs.push_back('{"maddu_wrap",   OP_MADDU, 32'd1,         32'd1,        64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd0,                 3});
    vecs.push_back('{"multu_max",    OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0,                0, 64'hFFFF_FFFE_0000_0001, 3});
    vecs.push_back('{"mthi",         OP_MTHI,  32'hABCD_0123, 32'd0,        64'h1111_1111_2222_2222, 0, 64'hABCD_0123_2222_2222, 0});
    vecs.push_back('{"mtlo",         OP_MTLO,  32'd5,         32'd0,        64'h1111_1111_2222_2222, 0, 64'h1111_1111_0000_0005, 0});
    vecs.push_back('{"divu_100_7",   OP_DIVU,  32'd100,       32'd7,        64'd0,                 0, 64'h0000_0002_0000_000E, 34});
    vecs.push_back('{"msub_neg",     OP_MSUB,  32'd3,         32'hFFFF_FFFE, 64'd10,               0, 64'd16,                  3});
    vecs.push_back('{"div_min_2",    OP_DIV,   32'h8000_0000, 32'd2,        64'd0,                 0, 64'h0000_0000_C000_0000, 34});

    // Reset state
    rst = 1'b0;
    step();
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_hilo_we", 64'(hilo_we), 64'd0);
    check("rst_hilo_wr", hilo_wr, 64'd0);
    rst = 1'b1;
    step();

    // Directed vector table
    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hilo,
             vecs[i].ack_delay, vecs[i].exp, vecs[i].lat);

    // Flush in the middle of a divide, then a zero-latency MTLO
    req_valid = 1'b1; req_op = OP_DIVU; req_reg0 = 32'd1000; req_reg1 = 32'd3; hilo_rd = '0;
    #1;
    for (int k = 0; k < 10; k++) step();
    check("flush_div_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    #1;
    check("flush_div_no_we", 64'(hilo_we), 64'd0);
    step();
    flush = 1'b0;
    req_valid = 1'b0;
    #1;
    check("flush_div_busy", 64'(busy), 64'd0);
    check("flush_div_ready", 64'(ready), 64'd0);
    run_op("mtlo_after_flush", OP_MTLO, 32'h0000_1234, 32'd0, 64'hCAFE_F00D_5555_5555, 0,
           64'hCAFE_F00D_0000_1234, 0);

    // Flush and ack together in DONE: flush wins
    req_valid = 1'b1; req_op = OP_MULT; req_reg0 = 32'd5; req_reg1 = 32'd5; hilo_rd = '0;
    #1;
    wait_n = 0;
    while (!ready && wait_n < MAX_WAIT) begin
      step();
      wait_n++;
    end
    check("flush_done_reached", 64'(ready), 64'd1);
    ack = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_done_no_we", 64'(hilo_we), 64'd0);
    step();
    ack = 1'b0; flush = 1'b0; req_valid = 1'b0;
    #1;
    check("flush_done_idle", 64'(busy), 64'd0);

    // Flush in IDLE masks the MTHI strobe
    req_valid = 1'b1; req_op = OP_MTHI; req_reg0 = 32'h5A5A_5A5A; ack = 1'b1; flush = 1'b1;
    #1;
    check("flush_idle_mthi_we", 64'(hilo_we), 64'd0);
    step();
    req_valid = 1'b0; ack = 1'b0; flush = 1'b0;
    #1;

    // Reset asserted mid-MUL
    req_valid = 1'b1; req_op = OP_MULT; req_reg0 = 32'd9; req_reg1 = 32'd9; hilo_rd = '0;
    #1;
    step();
    check("rst_mid_busy_before", 64'(busy), 64'd1);
    req_valid = 1'b0;
    rst = 1'b0;
    step();
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_ready", 64'(ready), 64'd0);
    check("rst_mid_hilo_we", 64'(hilo_we), 64'd0);
    check("rst_mid_hilo_wr", hilo_wr, 64'd0);
    rst = 1'b1;
    step();
    run_op("multu_after_rst", OP_MULTU, 32'd2, 32'd2, 64'd0, 0, 64'd4, 3);

    // Randomized ops against the reference model
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU,
            OP_MSUB, OP_MSUBU, OP_MTHI, OP_MTLO};
    for (int n = 0; n < 40; n++) begin
      oper_t       op;
      logic [31:0] a, b;
      logic [63:0] h;
      op = ops[$urandom_range(0, 9)];
      a  = rand_word();
      b  = rand_word();
      h  = {$urandom, $urandom};
      run_op($sformatf("rand%0d_%s", n, op.name()), op, a, b, h, $urandom_range(0, 2),
             model_result(op, a, b, h), model_latency(op));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
